sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_pkg.sv | 26 ++
 rtl/sdram_request_slot.sv | 47 ++++
 rtl/sdram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter.
// Holds the command field widths, the packed command record that both
// request slots carry, and the arbiter state encoding.
package sdram_port_arbiter_pkg;

  localparam int unsigned ADDRESS_WIDTH = 23;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned MASK_WIDTH    = 4;
  localparam int unsigned BURST_WIDTH   = 9;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic [MASK_WIDTH-1:0]    mask;
    logic [BURST_WIDTH-1:0]   burst_length;
  } sdram_cmd_t;

  localparam int unsigned CMD_WIDTH = $bits(sdram_cmd_t);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

endpackage

// File: rtl/sdram_request_slot.sv
// One pending-command slot for a requester.
// Latches a single-cycle request pulse together with its command fields and
// holds them until the arbiter issues the command.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   request      requester pulse; cmd_in is valid with it
//   cmd_in       packed command fields from the requester
//   busy         this requester's command is currently granted
//   issue        arbiter is issuing this slot's command this cycle
//   avail        a command is available (stored, or arriving this cycle)
//   cmd_out      the available command (stored copy, or bypassed input)
module sdram_request_slot
  import sdram_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 request,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 busy,
  input  logic                 issue,
  output logic                 avail,
  output logic [CMD_WIDTH-1:0] cmd_out
);

  logic                 pending_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 accept;

  // A pulse while already pending or granted is dropped; the stored copy wins.
  assign accept  = request && !pending_q && !busy;
  // Bypass lets an idle arbiter issue a fresh pulse without a storage cycle.
  assign avail   = pending_q || accept;
  assign cmd_out = pending_q ? cmd_q : cmd_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      cmd_q     <= '0;
    end else if (issue) begin
      pending_q <= 1'b0;
    end else if (accept) begin
      pending_q <= 1'b1;
      cmd_q     <= cmd_in;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port (writer/reader) arbiter in front of a single-command SDRAM
// controller. Reads have priority, but a pending write is forced through
// after READ_STREAK_LIMIT consecutive read grants.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   w_request + w_* fields           writer command pulse and fields
//   w_done                           write completion pulse
//   r_request + r_* fields           reader command pulse and fields
//   r_data, r_data_valid, r_done     read words (1-cycle delayed) and completion
//   sd_request, sd_write, sd_*       command pulse and held fields to controller
//   sd_rdata, sd_rdata_valid         read words from controller
//   sd_done                          controller completion pulse
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned READ_STREAK_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_request,
  input  logic [ADDRESS_WIDTH-1:0] w_address,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic [MASK_WIDTH-1:0]    w_mask,
  input  logic [BURST_WIDTH-1:0]   w_burst_length,
  output logic                     w_done,
  input  logic                     r_request,
  input  logic [ADDRESS_WIDTH-1:0] r_address,
  input  logic [BURST_WIDTH-1:0]   r_burst_length,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     r_data_valid,
  output logic                     r_done,
  output logic                     sd_request,
  output logic                     sd_write,
  output logic [ADDRESS_WIDTH-1:0] sd_address,
  output logic [DATA_WIDTH-1:0]    sd_wdata,
  output logic [MASK_WIDTH-1:0]    sd_mask,
  output logic [BURST_WIDTH-1:0]   sd_burst_length,
  input  logic [DATA_WIDTH-1:0]    sd_rdata,
  input  logic                     sd_rdata_valid,
  input  logic                     sd_done
);

  localparam int unsigned STREAK_WIDTH = $clog2(READ_STREAK_LIMIT + 1);

  arb_state_e              state_q;
  logic                    grant_read_q;
  logic [STREAK_WIDTH-1:0] streak_q;

  logic                 w_avail, r_avail;
  logic [CMD_WIDTH-1:0] w_cmd_in, r_cmd_in, w_slot_cmd, r_slot_cmd;
  logic                 w_busy, r_busy, releasing;
  logic                 streak_full, pick_write, w_issue, r_issue, read_active;
  sdram_cmd_t           sel_cmd;

  assign w_cmd_in = {w_address, w_data, w_mask, w_burst_length};
  assign r_cmd_in = {r_address, {DATA_WIDTH{1'b0}}, {MASK_WIDTH{1'b0}}, r_burst_length};

  // The granted slot frees up in the sd_done cycle so a pulse there is kept.
  assign releasing   = (state_q == StWait) && sd_done;
  assign w_busy      = (state_q != StIdle) && !grant_read_q && !releasing;
  assign r_busy      = (state_q != StIdle) && grant_read_q && !releasing;
  assign read_active = (state_q != StIdle) && grant_read_q;

  assign streak_full = (streak_q == STREAK_WIDTH'(READ_STREAK_LIMIT));
  assign pick_write  = w_avail && (!r_avail || streak_full);
  assign w_issue     = (state_q == StIdle) && pick_write;
  assign r_issue     = (state_q == StIdle) && r_avail && !pick_write;
  assign sel_cmd     = pick_write ? w_slot_cmd : r_slot_cmd;

  sdram_request_slot u_write_slot (
    .clk     (clk),
    .reset   (reset),
    .request (w_request),
    .cmd_in  (w_cmd_in),
    .busy    (w_busy),
    .issue   (w_issue),
    .avail   (w_avail),
    .cmd_out (w_slot_cmd)
  );

  sdram_request_slot u_read_slot (
    .clk     (clk),
    .reset   (reset),
    .request (r_request),
    .cmd_in  (r_cmd_in),
    .busy    (r_busy),
    .issue   (r_issue),
    .avail   (r_avail),
    .cmd_out (r_slot_cmd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      grant_read_q    <= 1'b0;
      streak_q        <= '0;
      sd_request      <= 1'b0;
      sd_write        <= 1'b0;
      sd_address      <= '0;
      sd_wdata        <= '0;
      sd_mask         <= '0;
      sd_burst_length <= '0;
      w_done          <= 1'b0;
      r_done          <= 1'b0;
      r_data          <= '0;
      r_data_valid    <= 1'b0;
    end else begin
      sd_request   <= 1'b0;
      w_done       <= 1'b0;
      r_done       <= 1'b0;
      // Controller read data only belongs to us while a read is granted.
      r_data_valid <= read_active && sd_rdata_valid;
      if (read_active && sd_rdata_valid) begin
        r_data <= sd_rdata;
      end

      unique case (state_q)
        StIdle: begin
          if (!w_avail) begin
            streak_q <= '0;
          end
          if (w_issue || r_issue) begin
            state_q         <= StIssue;
            sd_request      <= 1'b1;
            sd_write        <= w_issue;
            grant_read_q    <= r_issue;
            sd_address      <= sel_cmd.address;
            sd_wdata        <= sel_cmd.data;
            sd_mask         <= sel_cmd.mask;
            sd_burst_length <= sel_cmd.burst_length;
            if (w_issue) begin
              streak_q <= '0;
            end else if (w_avail && !streak_full) begin
              streak_q <= streak_q + 1'b1;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (sd_done) begin
            state_q <= StIdle;
            r_done  <= grant_read_q;
            w_done  <= !grant_read_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by
// a randomized phase, all checked against a transaction-level reference model
// (pending commands, read streak, controller responses) kept in the bench.
module tb_sdram_port_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_request, r_request, w_done, r_done, r_data_valid;
  logic [22:0] w_address, r_address, sd_address;
  logic [31:0] w_data, r_data, sd_wdata, sd_rdata;
  logic [3:0]  w_mask, sd_mask;
  logic [8:0]  w_burst_length, r_burst_length, sd_burst_length;
  logic        sd_request, sd_write, sd_rdata_valid, sd_done;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.READ_STREAK_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .w_request       (w_request),
    .w_address       (w_address),
    .w_data          (w_data),
    .w_mask          (w_mask),
    .w_burst_length  (w_burst_length),
    .w_done          (w_done),
    .r_request       (r_request),
    .r_address       (r_address),
    .r_burst_length  (r_burst_length),
    .r_data          (r_data),
    .r_data_valid    (r_data_valid),
    .r_done          (r_done),
    .sd_request      (sd_request),
    .sd_write        (sd_write),
    .sd_address      (sd_address),
    .sd_wdata        (sd_wdata),
    .sd_mask         (sd_mask),
    .sd_burst_length (sd_burst_length),
    .sd_rdata        (sd_rdata),
    .sd_rdata_valid  (sd_rdata_valid),
    .sd_done         (sd_done)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: pending/granted commands per requester and read streak.
  bit          w_pend, r_pend, w_granted, r_granted, outstanding, idle_prev;
  logic [22:0] w_pa, r_pa;
  logic [31:0] w_pd;
  logic [3:0]  w_pm;
  logic [8:0]  w_pb, r_pb;
  int          streak;

  // Fields to drive with the next pulses.
  logic [22:0] nw_a, nr_a;
  logic [31:0] nw_d;
  logic [3:0]  nw_m;
  logic [8:0]  nw_b, nr_b;

  // Controller model and one-cycle-ahead expectations.
  bit          ctl_active, ctl_write, ctl_hold;
  int          ctl_words, ctl_delay;
  bit          exp_rv, exp_wdone, exp_rdone;
  logic [31:0] exp_rd;

  bit r_auto, w_on_done, rand_mode;
  int gap_pct;

  // Observations taken from the DUT outputs.
  int obs_wdone, obs_rdone, obs_rwords, obs_wiss, obs_riss, wiss_cyc, rdone_cyc;
  bit issue_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit wp_in, input bit rp_in);
    bit          exp_req, pw, just_issued, rv, sdone, wp, rp;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;

    if (sd_request === 1'b1) begin
      issue_log.push_back(sd_write);
      if (sd_write === 1'b1) begin
        obs_wiss++;
        wiss_cyc = cyc;
      end else begin
        obs_riss++;
      end
    end
    if (w_done === 1'b1) obs_wdone++;
    if (r_done === 1'b1) begin
      obs_rdone++;
      rdone_cyc = cyc;
    end
    if (r_data_valid === 1'b1) obs_rwords++;

    // A command goes out the cycle after the arbiter sat idle with work pending.
    exp_req = idle_prev && (w_pend || r_pend);
    chk("sd_request", sd_request, exp_req);
    just_issued = 1'b0;
    if (exp_req) begin
      pw = w_pend && (!r_pend || streak == LIMIT);
      chk("sd_write", sd_write, pw);
      if (pw) begin
        chk("wr_address", sd_address, w_pa);
        chk("wr_data", sd_wdata, w_pd);
        chk("wr_mask", sd_mask, w_pm);
        chk("wr_burst", sd_burst_length, w_pb);
        w_pend    = 1'b0;
        w_granted = 1'b1;
        streak    = 0;
        ctl_words = 0;
      end else begin
        chk("rd_address", sd_address, r_pa);
        chk("rd_burst", sd_burst_length, r_pb);
        r_pend    = 1'b0;
        r_granted = 1'b1;
        if (w_pend && streak < LIMIT) streak++;
        ctl_words = int'(r_pb);
      end
      outstanding = 1'b1;
      ctl_active  = 1'b1;
      ctl_write   = pw;
      ctl_delay   = int'($urandom_range(1, 3));
      just_issued = 1'b1;
    end

    chk("r_data_valid", r_data_valid, exp_rv);
    if (exp_rv) chk("r_data", r_data, exp_rd);
    chk("w_done", w_done, exp_wdone);
    chk("r_done", r_done, exp_rdone);
    if (exp_wdone || exp_rdone) outstanding = 1'b0;

    // Controller behaviour for this cycle.
    rv        = 1'b0;
    sdone     = 1'b0;
    rd        = $urandom;
    exp_rv    = 1'b0;
    exp_wdone = 1'b0;
    exp_rdone = 1'b0;
    if (ctl_active) begin
      if (!ctl_write && ctl_words > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        rv        = 1'b1;
        ctl_words--;
        exp_rv    = 1'b1;
        exp_rd    = rd;
      end else if (ctl_write && $urandom_range(0, 3) == 0) begin
        rv = 1'b1;  // stray data during a write must be ignored
      end
      if (just_issued) begin
        if (rand_mode && $urandom_range(0, 3) == 0) sdone = 1'b1;  // ignored in ISSUE
      end else if (ctl_words == 0 && !ctl_hold) begin
        if (ctl_delay == 0) begin
          sdone      = 1'b1;
          ctl_active = 1'b0;
          if (ctl_write) begin
            w_granted = 1'b0;
            exp_wdone = 1'b1;
          end else begin
            r_granted = 1'b0;
            exp_rdone = 1'b1;
          end
        end else begin
          ctl_delay--;
        end
      end
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      sdone = 1'b1;  // ignored in IDLE
    end

    // Requesters.
    wp = wp_in;
    rp = rp_in;
    if (r_auto) rp = !r_pend && !r_granted;
    if (w_on_done && exp_rdone) wp = 1'b1;
    if (rand_mode) begin
      wp   = ($urandom_range(0, 9) == 0);
      rp   = ($urandom_range(0, 6) == 0);
      nw_a = 23'($urandom);
      nw_d = $urandom;
      nw_m = 4'($urandom);
      nw_b = 9'($urandom);
      nr_a = 23'($urandom);
      nr_b = 9'($urandom_range(1, 6));
    end
    if (wp && !w_pend && !w_granted) begin
      w_pend = 1'b1;
      w_pa   = nw_a;
      w_pd   = nw_d;
      w_pm   = nw_m;
      w_pb   = nw_b;
    end
    if (rp && !r_pend && !r_granted) begin
      r_pend = 1'b1;
      r_pa   = nr_a;
      r_pb   = nr_b;
    end

    w_request      = wp;
    w_address      = nw_a;
    w_data         = nw_d;
    w_mask         = nw_m;
    w_burst_length = nw_b;
    r_request      = rp;
    r_address      = nr_a;
    r_burst_length = nr_b;
    sd_rdata       = rd;
    sd_rdata_valid = rv;
    sd_done        = sdone;
    idle_prev      = !outstanding;
  endtask

  task automatic clear_inputs();
    w_request      = 1'b0;
    r_request      = 1'b0;
    sd_done        = 1'b0;
    sd_rdata_valid = 1'b0;
    sd_rdata       = '0;
    w_address      = '0;
    w_data         = '0;
    w_mask         = '0;
    w_burst_length = '0;
    r_address      = '0;
    r_burst_length = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    cyc++;
    chk("rst_sd_request", sd_request, 0);
    chk("rst_sd_write", sd_write, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_r_done", r_done, 0);
    chk("rst_r_data_valid", r_data_valid, 0);
    chk("rst_sd_address", sd_address, 0);
    chk("rst_sd_wdata", sd_wdata, 0);
    chk("rst_sd_mask", sd_mask, 0);
    chk("rst_sd_burst", sd_burst_length, 0);
    chk("rst_r_data", r_data, 0);
    reset       = 1'b0;
    w_pend      = 1'b0;
    r_pend      = 1'b0;
    w_granted   = 1'b0;
    r_granted   = 1'b0;
    outstanding = 1'b0;
    ctl_active  = 1'b0;
    exp_rv      = 1'b0;
    exp_wdone   = 1'b0;
    exp_rdone   = 1'b0;
    streak      = 0;
    idle_prev   = 1'b1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(outstanding || w_pend || r_pend || ctl_active || exp_rv)) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0);
    end
    chk("drain_timeout", ok, 1);
  endtask

  int base_w, base_r, rb, wb;

  initial begin
    reset = 1'b1;
    clear_inputs();
    gap_pct   = 20;
    r_auto    = 1'b0;
    w_on_done = 1'b0;
    rand_mode = 1'b0;
    ctl_hold  = 1'b0;
    do_reset();

    // Single write: issued the next cycle with its fields, then w_done.
    nw_a = 23'h000104; nw_d = 32'hF0000020; nw_m = 4'hF; nw_b = 9'd1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("single_wr_latency", sd_request, 1);
    chk("single_wr_is_write", sd_write, 1);
    chk("single_wr_address", sd_address, 32'h000104);
    chk("single_wr_data", sd_wdata, 32'hF0000020);
    drain();
    chk("single_wr_done_count", obs_wdone, 1);

    // Single 80-word read burst.
    nr_a = 23'h000200; nr_b = 9'd80;
    obs_rwords = 0;
    step(1'b0, 1'b1);
    drain();
    chk("burst80_words", obs_rwords, 80);
    chk("burst80_done_count", obs_rdone, 1);

    // Simultaneous requests: read first, write directly after r_done.
    nr_a = 23'h000333; nr_b = 9'd3;
    nw_a = 23'h000444; nw_d = 32'h12345678; nw_m = 4'h5; nw_b = 9'd2;
    issue_log.delete();
    step(1'b1, 1'b1);
    drain();
    chk("simul_issue_count", issue_log.size(), 2);
    if (issue_log.size() == 2) begin
      chk("simul_first_is_read", issue_log[0], 0);
      chk("simul_second_is_write", issue_log[1], 1);
    end
    chk("simul_write_after_rdone", wiss_cyc - rdone_cyc, 1);

    // Continuous reads with one write pending: write after exactly LIMIT reads.
    nr_b = 9'd2;
    r_auto = 1'b1;
    base_r = obs_riss;
    for (int i = 0; i < 50 && obs_riss == base_r; i++) step(1'b0, 1'b0);
    nw_a = 23'h0000AA;
    step(1'b1, 1'b0);
    rb = obs_riss;
    wb = obs_wiss;
    for (int i = 0; i < 1000 && obs_wiss == wb; i++) step(1'b0, 1'b0);
    chk("streak_write_issued", obs_wiss - wb, 1);
    chk("streak_reads_before_write", obs_riss - rb, LIMIT);
    r_auto = 1'b0;
    drain();

    // Write pulse in the same cycle as sd_done of a read.
    nr_b = 9'd3;
    nw_a = 23'h000555;
    base_w = obs_wdone;
    w_on_done = 1'b1;
    wb = obs_wiss;
    step(1'b0, 1'b1);
    for (int i = 0; i < 200 && obs_wiss == wb; i++) step(1'b0, 1'b0);
    w_on_done = 1'b0;
    drain();
    chk("done_cycle_write_issued", obs_wiss - wb, 1);
    chk("done_cycle_write_after_rdone", wiss_cyc - rdone_cyc, 1);
    chk("done_cycle_w_done", obs_wdone - base_w, 1);

    // Reset while waiting: no done pulse, next request served normally.
    ctl_hold = 1'b1;
    nw_a = 23'h000666;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    base_w = obs_wdone;
    do_reset();
    ctl_hold = 1'b0;
    repeat (5) step(1'b0, 1'b0);
    chk("reset_no_done", obs_wdone - base_w, 0);
    nw_a = 23'h000777;
    step(1'b1, 1'b0);
    drain();
    chk("reset_then_served", obs_wdone - base_w, 1);

    // Randomized traffic, including dropped pulses and stray sd_done.
    rand_mode = 1'b1;
    gap_pct   = 30;
    repeat (4000) step(1'b0, 1'b0);
    rand_mode = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
